// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG decoder chroma path: sample width,
// the Cb/Cr pair type and a helper for sizing counters and addresses.
package jpeg_pkg;

    localparam int PIX_W = 8;

    typedef struct packed {
        logic [PIX_W-1:0] cb;
        logic [PIX_W-1:0] cr;
    } chroma_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_from_size(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chroma_line_buffer.sv
// One chroma row of Cb/Cr pairs: single write port, combinational read port,
// so odd output rows can replay the row captured on the preceding even row.
module chroma_line_buffer
    import jpeg_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = width_from_size(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  chroma_t           i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output chroma_t           o_rdata
);

    chroma_t r_mem [DEPTH];

    // NOTE: storage is deliberately left out of reset; every entry is written
    // on the even row before the odd row reads it, so reset would only cost logic.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/upsampler_420.sv
// 4:2:0 -> 4:4:4 chroma upsampler: nearest-neighbour replication, each sample
// doubled horizontally and each chroma row replayed from a line buffer.
module upsampler_420
    import jpeg_pkg::*;
#(
    parameter int IMG_WIDTH  = 16,
    parameter int IMG_HEIGHT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] cb_in,
    input  logic [PIX_W-1:0] cr_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [PIX_W-1:0] cb_out,
    output logic [PIX_W-1:0] cr_out,
    output logic             valid_out,
    input  logic             ready_out,
    output logic             eol_out,
    output logic             eof_out
);

    localparam int X_W      = width_from_size(IMG_WIDTH);
    localparam int Y_W      = width_from_size(IMG_HEIGHT);
    localparam int LB_DEPTH = IMG_WIDTH / 2;
    localparam int LB_AW    = width_from_size(LB_DEPTH);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_HEIGHT - 1);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    chroma_t        r_hold;
    chroma_t        r_out;
    logic           r_valid;
    logic           r_eol;
    logic           r_eof;

    logic             w_loadable;
    logic             w_in_slot;
    logic             w_has_src;
    logic             w_load;
    logic             w_take_in;
    logic             w_x_last;
    logic             w_y_last;
    chroma_t          w_in;
    chroma_t          w_src;
    chroma_t          w_lb_rdata;
    logic [LB_AW-1:0] w_lb_addr;

    assign w_in       = '{cb: cb_in, cr: cr_in};
    assign w_loadable = !r_valid || ready_out;
    // Only even rows at even columns consume a new sample.
    assign w_in_slot  = !r_y[0] && !r_x[0];
    assign w_has_src  = !w_in_slot || valid_in;
    assign w_load     = w_loadable && w_has_src;
    assign w_take_in  = w_in_slot && valid_in && w_loadable;
    assign w_x_last   = (r_x == X_LAST);
    assign w_y_last   = (r_y == Y_LAST);
    assign w_lb_addr  = LB_AW'(r_x >> 1);

    assign ready_in   = w_in_slot && w_loadable;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_src = w_lb_rdata;
        if (!r_y[0]) begin
            w_src = r_x[0] ? r_hold : w_in;
        end
    end

    chroma_line_buffer #(
        .DEPTH  (LB_DEPTH),
        .ADDR_W (LB_AW)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_take_in),
        .i_waddr (w_lb_addr),
        .i_wdata (w_in),
        .i_raddr (w_lb_addr),
        .o_rdata (w_lb_rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_hold  <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;
        end else begin
            if (w_take_in) begin
                r_hold <= w_in;
            end
            if (w_load) begin
                r_out   <= w_src;
                r_valid <= 1'b1;
                r_eol   <= w_x_last;
                r_eof   <= w_x_last && w_y_last;
                if (w_x_last) begin
                    r_x <= '0;
                    r_y <= w_y_last ? '0 : r_y + Y_W'(1);
                end else begin
                    r_x <= r_x + X_W'(1);
                end
            end else if (ready_out) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign cb_out    = r_out.cb;
    assign cr_out    = r_out.cr;
    assign valid_out = r_valid;
    assign eol_out   = r_eol;
    assign eof_out   = r_eof;

endmodule
